// File: rtl/writeback_pkg.sv
// Shared types and encodings for the write-back stage: load size codes,
// the hard-wired zero register and the layout of one buffered result.
package writeback_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   localparam logic [4:0] REG_ZERO = 5'd0;

   localparam int XLEN = 32;

   typedef struct packed {
      logic [4:0]      rd;
      logic            wen_eff;
      logic [XLEN-1:0] data;
   } fifo_entry_t;

endpackage

// File: rtl/load_formatter.sv
// Extracts and extends the addressed byte or halfword from a raw memory word.
// Size code 3 is handled the same as a full word.
module load_formatter
   import writeback_pkg::*;
(
   input  logic [31:0] in_mem,
   input  logic [1:0]  in_size,
   input  logic        in_unsigned,
   input  logic [1:0]  in_byteoff,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      byte_sel = in_mem[7:0];
      case (in_byteoff)
         2'd1:    byte_sel = in_mem[15:8];
         2'd2:    byte_sel = in_mem[23:16];
         2'd3:    byte_sel = in_mem[31:24];
         default: byte_sel = in_mem[7:0];
      endcase

      half_sel = in_byteoff[1] ? in_mem[31:16] : in_mem[15:0];

      data = in_mem;
      case (in_size)
         SZ_BYTE: data = {{24{~in_unsigned & byte_sel[7]}}, byte_sel};
         SZ_HALF: data = {{16{~in_unsigned & half_sel[15]}}, half_sel};
         default: data = in_mem;
      endcase
   end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: buffers completed results in an in-order FIFO, drains the
// head into the register bank write port and forwards pending results to decode.
module writeback_unit
   import writeback_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 32
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_rd,
   input  logic              in_wen,
   input  logic              in_memtoreg,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [DATA_W-1:0] in_mem,
   input  logic [1:0]        in_size,
   input  logic              in_unsigned,
   input  logic [1:0]        in_byteoff,
   input  logic              wr_grant,
   output logic              wr_en,
   output logic [4:0]        wr_addr,
   output logic [DATA_W-1:0] wr_data,
   input  logic [4:0]        rd_addr1,
   input  logic [4:0]        rd_addr2,
   output logic              fwd_valid1,
   output logic              fwd_valid2,
   output logic [DATA_W-1:0] fwd_data1,
   output logic [DATA_W-1:0] fwd_data2,
   output logic [31:0]       retire_count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   fifo_entry_t   fifo_q [DEPTH];
   fifo_entry_t   fifo_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   retire_count_q, retire_count_d;

   logic [31:0]   load_data;
   fifo_entry_t   entry_in;
   fifo_entry_t   head;
   logic          nonempty;
   logic          push;
   logic          pop;
   logic [AW-1:0] fwd_idx;

   load_formatter u_load_formatter (
      .in_mem      (in_mem),
      .in_size     (in_size),
      .in_unsigned (in_unsigned),
      .in_byteoff  (in_byteoff),
      .data        (load_data)
   );

   assign nonempty = (count_q != '0);
   assign in_ready = ~reset & (count_q < CW'(DEPTH));
   assign push     = in_valid & in_ready;
   assign pop      = nonempty & wr_grant;

   assign head         = fifo_q[rd_ptr_q];
   assign wr_en        = nonempty & head.wen_eff & wr_grant;
   assign wr_addr      = nonempty ? head.rd : REG_ZERO;
   assign wr_data      = nonempty ? head.data : '0;
   assign retire_count = retire_count_q;

   always_comb begin
      entry_in.rd      = in_rd;
      entry_in.wen_eff = in_wen & (in_rd != REG_ZERO);
      entry_in.data    = in_memtoreg ? load_data : in_alu;
   end

   always_comb begin
      fifo_d         = fifo_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      retire_count_d = retire_count_q;
      if (push) begin
         fifo_d[wr_ptr_q] = entry_in;
         wr_ptr_d         = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d       = rd_ptr_q + AW'(1);
         retire_count_d = retire_count_q + 32'd1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
   end

   // Walk entries oldest to youngest so the last match (the youngest) wins.
   always_comb begin
      fwd_valid1 = 1'b0;
      fwd_data1  = '0;
      fwd_valid2 = 1'b0;
      fwd_data2  = '0;
      fwd_idx    = rd_ptr_q;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = rd_ptr_q + AW'(i);
         if ((CW'(i) < count_q) && fifo_q[fwd_idx].wen_eff) begin
            if ((rd_addr1 != REG_ZERO) && (fifo_q[fwd_idx].rd == rd_addr1)) begin
               fwd_valid1 = 1'b1;
               fwd_data1  = fifo_q[fwd_idx].data;
            end
            if ((rd_addr2 != REG_ZERO) && (fifo_q[fwd_idx].rd == rd_addr2)) begin
               fwd_valid2 = 1'b1;
               fwd_data2  = fifo_q[fwd_idx].data;
            end
         end
      end
   end

   // NOTE: sequential state is assigned with non-blocking <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         retire_count_q <= '0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         retire_count_q <= retire_count_d;
      end
   end

   // NOTE: the storage array is not reset; count_q alone decides which entries are live.
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_writeback_unit;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic        in_wen;
   logic        in_memtoreg;
   logic [31:0] in_alu;
   logic [31:0] in_mem;
   logic [1:0]  in_size;
   logic        in_unsigned;
   logic [1:0]  in_byteoff;
   logic        wr_grant;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [4:0]  rd_addr1, rd_addr2;
   logic        fwd_valid1, fwd_valid2;
   logic [31:0] fwd_data1, fwd_data2;
   logic [31:0] retire_count;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit [4:0]  rd;
      bit        wen;
      bit [31:0] data;
   } m_ent_t;

   m_ent_t      mq[$];
   int unsigned m_ret = 0;

   writeback_unit #(.DEPTH(DEPTH), .DATA_W(32)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_rd(in_rd), .in_wen(in_wen), .in_memtoreg(in_memtoreg), .in_alu(in_alu),
      .in_mem(in_mem), .in_size(in_size), .in_unsigned(in_unsigned),
      .in_byteoff(in_byteoff), .wr_grant(wr_grant), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .fwd_valid1(fwd_valid1), .fwd_valid2(fwd_valid2), .fwd_data1(fwd_data1),
      .fwd_data2(fwd_data2), .retire_count(retire_count)
   );

   always #5 clk = ~clk;

   // Load formatting from the rules: shift the addressed unit down, mask, extend.
   function automatic bit [31:0] fmt(input bit [31:0] mem, input bit [1:0] size,
                                     input bit uns, input bit [1:0] off);
      int        bits;
      int        sh;
      bit [31:0] mask;
      bit [31:0] v;
      if (size == 2'd0) begin
         bits = 8;  sh = 8 * off;
      end else if (size == 2'd1) begin
         bits = 16; sh = 16 * (off / 2);
      end else begin
         return mem;
      end
      mask = (32'h1 << bits) - 32'h1;
      v    = (mem >> sh) & mask;
      if (!uns && v[bits-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic void m_fwd(input bit [4:0] a, output bit v, output bit [31:0] d);
      v = 1'b0;
      d = '0;
      if (a != 5'd0)
         foreach (mq[i])
            if (mq[i].wen && mq[i].rd == a) begin
               v = 1'b1;
               d = mq[i].data;
            end
   endfunction

   // One clock: model takes the same transfer decisions the spec prescribes.
   task automatic tick();
      bit     push, pop;
      m_ent_t e;
      push   = !reset && in_valid && (mq.size() < DEPTH);
      pop    = (mq.size() != 0) && wr_grant;
      e.rd   = in_rd;
      e.wen  = in_wen && (in_rd != 5'd0);
      e.data = in_memtoreg ? fmt(in_mem, in_size, in_unsigned, in_byteoff) : in_alu;
      @(posedge clk);
      if (reset) begin
         mq.delete();
         m_ret = 0;
      end else begin
         if (pop) begin
            mq.delete(0);
            m_ret++;
         end
         if (push) mq.push_back(e);
      end
      #1;
   endtask

   task automatic offer_alu(input bit [4:0] rd, input bit [31:0] v);
      in_valid    = 1'b1;
      in_rd       = rd;
      in_wen      = 1'b1;
      in_memtoreg = 1'b0;
      in_alu      = v;
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      in_valid = 1'b1;
      tick();
      tick();
      #2;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", in_ready); end
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b want=0", wr_en); end
      total++; if (wr_data !== 32'h0) begin bad++; $display("FAIL reset_wr_data got=%h want=0", wr_data); end
      total++; if (fwd_valid1 !== 1'b0 || fwd_valid2 !== 1'b0) begin bad++; $display("FAIL reset_fwd got=%b%b want=00", fwd_valid1, fwd_valid2); end
      total++; if (retire_count !== 32'd0) begin bad++; $display("FAIL reset_retire got=%0d want=0", retire_count); end
      in_valid = 1'b0;
      tick();
      reset = 1'b0;
      #2;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", in_ready); end
   endtask

   task automatic test_alu_write();
      wr_grant = 1'b1;
      offer_alu(5'd5, 32'h1234);
      tick();
      in_valid = 1'b0;
      #2;
      total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL alu_wr_en got=%b want=1", wr_en); end
      total++; if (wr_addr !== 5'd5) begin bad++; $display("FAIL alu_wr_addr got=%0d want=5", wr_addr); end
      total++; if (wr_data !== 32'h1234) begin bad++; $display("FAIL alu_wr_data got=%h want=00001234", wr_data); end
      tick();
      #2;
      total++; if (retire_count !== 32'd1) begin bad++; $display("FAIL alu_retire got=%0d want=1", retire_count); end
   endtask

   task automatic test_loads();
      bit [1:0]  sz  [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
      bit [1:0]  off [5] = '{2'd1, 2'd3, 2'd2, 2'd3, 2'd2};
      bit        un  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      bit [31:0] exp [5] = '{32'h0000007F, 32'hFFFFFF80, 32'h000080FF, 32'hFFFF80FF, 32'h80FF7F01};
      wr_grant = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_valid    = 1'b1;
         in_rd       = 5'd3;
         in_wen      = 1'b1;
         in_memtoreg = 1'b1;
         in_alu      = $urandom;
         in_mem      = 32'h80FF7F01;
         in_size     = sz[k];
         in_unsigned = un[k];
         in_byteoff  = off[k];
         tick();
         in_valid = 1'b0;
         #2;
         total++;
         if (wr_en !== 1'b1 || wr_data !== exp[k]) begin
            bad++;
            $display("FAIL load_%0d got en=%b data=%h want en=1 data=%h", k, wr_en, wr_data, exp[k]);
         end
         tick();
      end
   endtask

   task automatic test_back_pressure();
      bit [4:0]    exp_rd [3] = '{5'd1, 5'd2, 5'd3};
      int          got = 0;
      int unsigned base;
      base     = m_ret;
      wr_grant = 1'b0;
      offer_alu(5'd1, 32'h11);
      tick();
      offer_alu(5'd2, 32'h22);
      tick();
      offer_alu(5'd3, 32'h33);
      #2;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b want=0", in_ready); end
      tick();
      #2;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_held_ready got=%b want=0", in_ready); end
      wr_grant = 1'b1;
      for (int cyc = 0; cyc < 10 && got < 3; cyc++) begin
         #1;
         if (wr_en) begin
            total++;
            if (wr_addr !== exp_rd[got] || wr_data !== {exp_rd[got], exp_rd[got]} * 32'h1 + 32'h0 - {exp_rd[got], exp_rd[got]} + 32'h11 * exp_rd[got]) begin
               bad++;
               $display("FAIL bp_order_%0d got addr=%0d data=%h want addr=%0d data=%h", got, wr_addr, wr_data, exp_rd[got], 32'h11 * exp_rd[got]);
            end
            got++;
         end
         if (in_valid && in_ready) begin
            tick();
            in_valid = 1'b0;
         end else begin
            tick();
         end
      end
      total++; if (got !== 3) begin bad++; $display("FAIL bp_write_count got=%0d want=3", got); end
      #2;
      total++; if (retire_count !== base + 32'd3) begin bad++; $display("FAIL bp_retire got=%0d want=%0d", retire_count, base + 3); end
   endtask

   task automatic test_forwarding();
      wr_grant = 1'b0;
      offer_alu(5'd7, 32'hA);
      tick();
      offer_alu(5'd7, 32'hB);
      tick();
      in_valid = 1'b0;
      rd_addr1 = 5'd7;
      rd_addr2 = 5'd0;
      #2;
      total++; if (fwd_valid1 !== 1'b1 || fwd_data1 !== 32'hB) begin bad++; $display("FAIL fwd_youngest got v=%b d=%h want v=1 d=0000000b", fwd_valid1, fwd_data1); end
      total++; if (fwd_valid2 !== 1'b0 || fwd_data2 !== 32'h0) begin bad++; $display("FAIL fwd_zero got v=%b d=%h want v=0 d=0", fwd_valid2, fwd_data2); end
      rd_addr2 = 5'd9;
      #1;
      total++; if (fwd_valid2 !== 1'b0 || fwd_data2 !== 32'h0) begin bad++; $display("FAIL fwd_nomatch got v=%b d=%h want v=0 d=0", fwd_valid2, fwd_data2); end
      wr_grant = 1'b1;
      tick();
      #2;
      total++; if (fwd_valid1 !== 1'b1 || fwd_data1 !== 32'hB || wr_en !== 1'b1) begin bad++; $display("FAIL fwd_head_writing got v=%b d=%h en=%b want v=1 d=0000000b en=1", fwd_valid1, fwd_data1, wr_en); end
      tick();
      #2;
      total++; if (fwd_valid1 !== 1'b0) begin bad++; $display("FAIL fwd_drained got=%b want=0", fwd_valid1); end
   endtask

   task automatic test_reg_zero();
      int unsigned base;
      base     = m_ret;
      wr_grant = 1'b1;
      rd_addr1 = 5'd0;
      offer_alu(5'd0, 32'hDEAD);
      tick();
      in_valid = 1'b0;
      #2;
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL r0_wr_en got=%b want=0", wr_en); end
      total++; if (fwd_valid1 !== 1'b0) begin bad++; $display("FAIL r0_fwd got=%b want=0", fwd_valid1); end
      tick();
      #2;
      total++; if (retire_count !== base + 32'd1) begin bad++; $display("FAIL r0_retire got=%0d want=%0d", retire_count, base + 1); end
   endtask

   task automatic test_reset_mid();
      wr_grant = 1'b0;
      offer_alu(5'd4, 32'h44);
      tick();
      offer_alu(5'd6, 32'h66);
      tick();
      in_valid = 1'b0;
      rd_addr1 = 5'd4;
      rd_addr2 = 5'd6;
      #2;
      total++; if (fwd_valid1 !== 1'b1 || fwd_valid2 !== 1'b1) begin bad++; $display("FAIL mid_buffered got=%b%b want=11", fwd_valid1, fwd_valid2); end
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      wr_grant = 1'b1;
      #2;
      total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL mid_wr_en got=%b want=0", wr_en); end
      total++; if (fwd_valid1 !== 1'b0 || fwd_valid2 !== 1'b0) begin bad++; $display("FAIL mid_fwd got=%b%b want=00", fwd_valid1, fwd_valid2); end
      total++; if (retire_count !== 32'd0) begin bad++; $display("FAIL mid_retire got=%0d want=0", retire_count); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want=1", in_ready); end
      for (int c = 0; c < 3; c++) begin
         tick();
         #2;
         total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL mid_no_write_%0d got=%b want=0", c, wr_en); end
      end
   endtask

   task automatic test_random();
      bit        ev1, ev2;
      bit [31:0] ed1, ed2;
      bit        e_en;
      bit [4:0]  e_addr;
      bit [31:0] e_data;
      for (int c = 0; c < 400; c++) begin
         reset       = ($urandom_range(0, 49) == 0);
         in_valid    = $urandom_range(0, 3) != 0;
         in_rd       = 5'($urandom_range(0, 7));
         in_wen      = $urandom_range(0, 4) != 0;
         in_memtoreg = $urandom_range(0, 1);
         in_alu      = $urandom;
         in_mem      = $urandom;
         in_size     = 2'($urandom_range(0, 3));
         in_unsigned = $urandom_range(0, 1);
         in_byteoff  = 2'($urandom_range(0, 3));
         wr_grant    = $urandom_range(0, 4) > 1;
         rd_addr1    = 5'($urandom_range(0, 7));
         rd_addr2    = 5'($urandom_range(0, 7));
         #2;
         m_fwd(rd_addr1, ev1, ed1);
         m_fwd(rd_addr2, ev2, ed2);
         e_en   = (mq.size() != 0) && mq[0].wen && wr_grant;
         e_addr = (mq.size() != 0) ? mq[0].rd : 5'd0;
         e_data = (mq.size() != 0) ? mq[0].data : 32'd0;
         total++; if (in_ready !== (!reset && mq.size() < DEPTH)) begin bad++; $display("FAIL rnd_ready c=%0d got=%b", c, in_ready); end
         total++; if (wr_en !== e_en) begin bad++; $display("FAIL rnd_wr_en c=%0d got=%b want=%b", c, wr_en, e_en); end
         total++; if (wr_addr !== e_addr || wr_data !== e_data) begin bad++; $display("FAIL rnd_head c=%0d got=%0d/%h want=%0d/%h", c, wr_addr, wr_data, e_addr, e_data); end
         total++; if (fwd_valid1 !== ev1 || fwd_data1 !== ed1) begin bad++; $display("FAIL rnd_fwd1 c=%0d got=%b/%h want=%b/%h", c, fwd_valid1, fwd_data1, ev1, ed1); end
         total++; if (fwd_valid2 !== ev2 || fwd_data2 !== ed2) begin bad++; $display("FAIL rnd_fwd2 c=%0d got=%b/%h want=%b/%h", c, fwd_valid2, fwd_data2, ev2, ed2); end
         total++; if (retire_count !== m_ret) begin bad++; $display("FAIL rnd_retire c=%0d got=%0d want=%0d", c, retire_count, m_ret); end
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      in_valid    = 1'b0;
      in_rd       = '0;
      in_wen      = 1'b0;
      in_memtoreg = 1'b0;
      in_alu      = '0;
      in_mem      = '0;
      in_size     = '0;
      in_unsigned = 1'b0;
      in_byteoff  = '0;
      wr_grant    = 1'b0;
      rd_addr1    = '0;
      rd_addr2    = '0;
      #1;
      test_reset();
      test_alu_write();
      test_loads();
      test_back_pressure();
      test_forwarding();
      test_reg_zero();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
